// File: rtl/btb_upd_if.sv
// btb_upd_if: resolver/fetch-side and BTB-write-side signals of the BTB update queue
interface btb_upd_if #(parameter int DEPTH = 4) ();
  localparam int PTR_W = $clog2(DEPTH);
  logic res_valid;
  logic [31:1] res_pc;
  logic res_taken;
  logic [31:0] res_target;
  logic res_pred_hit;
  logic [31:1] res_pred_target;
  logic fetch_btb_rd;
  logic fetch_hold;
  logic btb_wr;
  logic btb_invalid;
  logic [31:1] pc_w;
  logic [31:0] target_pc_w;
  logic upd_drop;
  logic [PTR_W:0] q_count;
  modport master (
    output res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, fetch_btb_rd,
    input fetch_hold, btb_wr, btb_invalid, pc_w, target_pc_w, upd_drop, q_count
  );
  modport slave (
    input res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, fetch_btb_rd,
    output fetch_hold, btb_wr, btb_invalid, pc_w, target_pc_w, upd_drop, q_count
  );
endinterface

// File: rtl/btb_upd_queue.sv
// btb_upd_queue: FIFO of BTB writes/invalidates drained on fetch-idle cycles; BTB_UPD_COALESCE_EN merges same-PC non-head entries
module btb_upd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  btb_upd_if.slave bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] NEAR = (PTR_W+1)'(DEPTH-1);
  logic [31:1] pc_q [DEPTH];
  logic [31:1] tgt_q [DEPTH];
  logic inv_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  logic [31:1] last_pc, last_tgt;
  logic last_inv, drop_r;
  logic need_wr, need_inv, need, hit, push, pop, drop, any;
  logic unused_ok;
  assign unused_ok = bus.res_target[0];
  always_comb begin
    need_wr = bus.res_taken & (!bus.res_pred_hit | (bus.res_pred_target != bus.res_target[31:1]));
    need_inv = !bus.res_taken & bus.res_pred_hit;
    need = bus.res_valid & (need_wr | need_inv);
    any = (count != '0);
    pop = any & !bus.fetch_btb_rd;
    push = need & !hit & ((count != FULL) | pop);
    drop = need & !hit & !push;
  end
`ifdef BTB_UPD_COALESCE_EN
  logic [PTR_W-1:0] hit_idx;
  // scan head+1 .. tail; the last match found is the youngest
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count) && (pc_q[rd_ptr + PTR_W'(k)] == bus.res_pc)) begin
        hit = need;
        hit_idx = rd_ptr + PTR_W'(k);
      end
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      last_pc <= '0;
      last_tgt <= '0;
      last_inv <= 1'b0;
      drop_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        tgt_q[i] <= '0;
        inv_q[i] <= 1'b0;
      end
    end else begin
      drop_r <= drop;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (pop) begin
        last_pc <= pc_q[rd_ptr];
        last_tgt <= tgt_q[rd_ptr];
        last_inv <= inv_q[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        pc_q[wr_ptr] <= bus.res_pc;
        tgt_q[wr_ptr] <= bus.res_target[31:1];
        inv_q[wr_ptr] <= need_inv;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
`ifdef BTB_UPD_COALESCE_EN
      if (hit) begin
        tgt_q[hit_idx] <= bus.res_target[31:1];
        inv_q[hit_idx] <= need_inv;
      end
`endif
    end
  end
  // empty queue keeps presenting the last retired entry
  assign bus.btb_wr = pop;
  assign bus.pc_w = any ? pc_q[rd_ptr] : last_pc;
  assign bus.target_pc_w = {any ? tgt_q[rd_ptr] : last_tgt, 1'b0};
  assign bus.btb_invalid = any ? inv_q[rd_ptr] : last_inv;
  assign bus.fetch_hold = (count >= NEAR);
  assign bus.upd_drop = drop_r;
  assign bus.q_count = count;
endmodule

// File: tb/tb_btb_upd_queue.sv
// tb_btb_upd_queue: queue-model scoreboard plus directed checks for btb_upd_queue
module tb_btb_upd_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  btb_upd_if #(.DEPTH(DEPTH)) bus();
  btb_upd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {logic [31:1] pc; logic [31:1] tgt; logic inv;} ent_t;
  ent_t q[$];
  ent_t last;
  logic m_drop;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last = '0;
      m_drop = 1'b0;
    end else begin : step
      logic wr, inv, need, hit, pop, push;
      int idx;
      wr = bus.res_taken && (!bus.res_pred_hit || bus.res_pred_target != bus.res_target[31:1]);
      inv = !bus.res_taken && bus.res_pred_hit;
      need = bus.res_valid && (wr || inv);
      hit = 1'b0;
      idx = 0;
`ifdef BTB_UPD_COALESCE_EN
      for (int i = q.size() - 1; i >= 1; i--)
        if (need && !hit && q[i].pc == bus.res_pc) begin
          hit = 1'b1;
          idx = i;
        end
`endif
      pop = q.size() != 0 && !bus.fetch_btb_rd;
      push = need && !hit && (q.size() < DEPTH || pop);
      m_drop = need && !hit && !push;
      if (hit) begin
        q[idx].tgt = bus.res_target[31:1];
        q[idx].inv = inv;
      end
      if (pop) last = q.pop_front();
      if (push) q.push_back('{bus.res_pc, bus.res_target[31:1], inv});
    end
  end
  always @(negedge clk) begin : cmp
    ent_t h;
    h = last;
    if (q.size() != 0) h = q[0];
    chk("btb_wr", {31'b0, bus.btb_wr}, {31'b0, q.size() != 0 && !bus.fetch_btb_rd});
    chk("pc_w", {1'b0, bus.pc_w}, {1'b0, h.pc});
    chk("target_pc_w", bus.target_pc_w, {h.tgt, 1'b0});
    chk("btb_invalid", {31'b0, bus.btb_invalid}, {31'b0, h.inv});
    chk("q_count", 32'(bus.q_count), 32'(q.size()));
    chk("fetch_hold", {31'b0, bus.fetch_hold}, {31'b0, q.size() >= DEPTH - 1});
    chk("upd_drop", {31'b0, bus.upd_drop}, {31'b0, m_drop});
  end
  task automatic cyc(input logic v, input logic [31:1] pc, input logic tk, input logic [31:0] tgt,
                     input logic ph, input logic [31:1] pt, input logic rd);
    bus.res_valid = v;
    bus.res_pc = pc;
    bus.res_taken = tk;
    bus.res_target = tgt;
    bus.res_pred_hit = ph;
    bus.res_pred_target = pt;
    bus.fetch_btb_rd = rd;
    @(posedge clk);
    #1 bus.res_valid = 1'b0;
  endtask
  task automatic wr(input logic [31:1] pc, input logic [31:0] tgt, input logic rd);
    cyc(1'b1, pc, 1'b1, tgt, 1'b0, '0, rd);
  endtask
  task automatic idle(input logic rd);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, rd);
  endtask
  initial begin
    bus.res_valid = 1'b0;
    bus.res_pc = '0;
    bus.res_taken = 1'b0;
    bus.res_target = '0;
    bus.res_pred_hit = 1'b0;
    bus.res_pred_target = '0;
    bus.fetch_btb_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_btb_wr", {31'b0, bus.btb_wr}, 0);
    chk("rst_q_count", 32'(bus.q_count), 0);
    chk("rst_hold", {31'b0, bus.fetch_hold}, 0);
    chk("rst_drop", {31'b0, bus.upd_drop}, 0);
    chk("rst_pc_w", {1'b0, bus.pc_w}, 0);
    chk("rst_target", bus.target_pc_w, 0);
    reset = 1'b0;
    wr(31'h408, 32'h0000_0A00, 1'b0);
    chk("mis_btb_wr", {31'b0, bus.btb_wr}, 1);
    chk("mis_pc_w", {1'b0, bus.pc_w}, 32'h408);
    chk("mis_target", bus.target_pc_w, 32'h0000_0A00);
    chk("mis_inval", {31'b0, bus.btb_invalid}, 0);
    idle(1'b0);
    chk("mis_count_after", 32'(bus.q_count), 0);
    chk("mis_pc_hold", {1'b0, bus.pc_w}, 32'h408);
    cyc(1'b1, 31'h100, 1'b1, 32'h200, 1'b1, 31'h100, 1'b0);
    chk("good_pred_count", 32'(bus.q_count), 0);
    cyc(1'b1, 31'h120, 1'b0, 32'h124, 1'b1, 31'h92, 1'b0);
    chk("false_hit_count", 32'(bus.q_count), 1);
    chk("false_hit_inval", {31'b0, bus.btb_invalid}, 1);
    chk("false_hit_pc", {1'b0, bus.pc_w}, 32'h120);
    idle(1'b0);
    wr(31'h10, 32'h40, 1'b1);
    wr(31'h20, 32'h80, 1'b1);
    chk("prio_count", 32'(bus.q_count), 2);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("prio_no_wr", {31'b0, bus.btb_wr}, 0);
    end
    bus.fetch_btb_rd = 1'b0;
    #1;
    chk("prio_wr1", {31'b0, bus.btb_wr}, 1);
    chk("prio_pc1", {1'b0, bus.pc_w}, 32'h10);
    @(posedge clk);
    #1;
    chk("prio_wr2", {31'b0, bus.btb_wr}, 1);
    chk("prio_tgt2", bus.target_pc_w, 32'h80);
    @(posedge clk);
    #1;
    chk("prio_empty", 32'(bus.q_count), 0);
    wr(31'h30, 32'h100, 1'b1);
    wr(31'h31, 32'h104, 1'b1);
    wr(31'h32, 32'h108, 1'b1);
    chk("full_hold", {31'b0, bus.fetch_hold}, 1);
    wr(31'h33, 32'h10C, 1'b1);
    chk("full_count4", 32'(bus.q_count), 4);
    wr(31'h34, 32'h1F0, 1'b1);
    chk("full_drop", {31'b0, bus.upd_drop}, 1);
    chk("full_drop_count", 32'(bus.q_count), 4);
    idle(1'b1);
    chk("drop_pulse_end", {31'b0, bus.upd_drop}, 0);
    wr(31'h35, 32'h110, 1'b0);
    chk("full_swap_count", 32'(bus.q_count), 4);
    chk("full_swap_nodrop", {31'b0, bus.upd_drop}, 0);
    repeat (4) idle(1'b0);
    chk("full_last_pc", {1'b0, bus.pc_w}, 32'h35);
    chk("full_drained", 32'(bus.q_count), 0);
    wr(31'h50, 32'h300, 1'b1);
    wr(31'h408, 32'hA00, 1'b1);
    wr(31'h408, 32'hC00, 1'b1);
    bus.fetch_btb_rd = 1'b0;
    #1;
    chk("co_head_tgt", bus.target_pc_w, 32'h300);
`ifdef BTB_UPD_COALESCE_EN
    chk("co_count", 32'(bus.q_count), 2);
    @(posedge clk);
    #1;
    chk("co_merged_tgt", bus.target_pc_w, 32'hC00);
`else
    chk("co_count", 32'(bus.q_count), 3);
    @(posedge clk);
    #1;
    chk("co_first_tgt", bus.target_pc_w, 32'hA00);
    @(posedge clk);
    #1;
    chk("co_second_tgt", bus.target_pc_w, 32'hC00);
`endif
    @(posedge clk);
    #1;
    chk("co_drained", 32'(bus.q_count), 0);
    wr(31'h60, 32'h200, 1'b1);
    wr(31'h61, 32'h204, 1'b1);
    wr(31'h62, 32'h208, 1'b1);
    chk("rmid_count", 32'(bus.q_count), 3);
    bus.fetch_btb_rd = 1'b0;
    #1;
    chk("rmid_wr_before", {31'b0, bus.btb_wr}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rmid_btb_wr", {31'b0, bus.btb_wr}, 0);
    chk("rmid_count0", 32'(bus.q_count), 0);
    chk("rmid_hold", {31'b0, bus.fetch_hold}, 0);
    #3 reset = 1'b0;
    idle(1'b0);
    idle(1'b0);
    chk("post_rst_count", 32'(bus.q_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
